// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and default widths for the master controller.
package axi_lite_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_DATA,
        DONE
    } mctrl_state_e;

endpackage

// File: rtl/axi_lite_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns start_write/start_read pulses
// into full AW+W->B or AR->R transactions and reports status via a done pulse.
module axi_lite_master_ctrl
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = AXI_ADDR_W,
    parameter int unsigned DATA_WIDTH = AXI_DATA_W,   // 32 or 64
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // command side
    input  logic                  start_write,
    input  logic                  start_read,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata_out,
    output logic [1:0]            resp_out,
    output logic                  cmd_dropped,
    // AXI write address / data / response
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    // AXI read address / data
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    mctrl_state_e          state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cmd_dropped_q, cmd_dropped_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_out_q, rdata_out_d;
    axi_resp_e             resp_q, resp_d;

    // Next-state and registered-output computation; every output is a flop,
    // so each valid/ready is set on the transition into the state that owns it.
    always_comb begin
        state_d       = state_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rdata_out_d   = rdata_out_q;
        resp_d        = resp_q;
        cmd_dropped_d = (state_q != IDLE) && (start_write || start_read);

        unique case (state_q)
            IDLE: begin
                if (start_write) begin
                    addr_d        = cmd_addr;
                    wdata_d       = cmd_wdata;
                    wstrb_d       = cmd_wstrb;
                    awvalid_d     = 1'b1;
                    wvalid_d      = 1'b1;
                    aw_done_d     = 1'b0;
                    w_done_d      = 1'b0;
                    busy_d        = 1'b1;
                    cmd_dropped_d = start_read;
                    state_d       = WR_REQ;
                end else if (start_read) begin
                    addr_d    = cmd_addr;
                    arvalid_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = RD_REQ;
                end
            end
            WR_REQ: begin
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_q && w_done_q) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bvalid && bready_q) begin
                    resp_d   = axi_resp_e'(bresp);
                    bready_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            RD_REQ: begin
                if (arvalid_q && arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rvalid && rready_q) begin
                    rdata_out_d = rdata;
                    resp_d      = axi_resp_e'(rresp);
                    rready_d    = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cmd_dropped_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rdata_out_q   <= '0;
            resp_q        <= OKAY;
        end else begin
            state_q       <= state_d;
            aw_done_q     <= aw_done_d;
            w_done_q      <= w_done_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cmd_dropped_q <= cmd_dropped_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rdata_out_q   <= rdata_out_d;
            resp_q        <= resp_d;
        end
    end

    assign awaddr      = addr_q;
    assign araddr      = addr_q;
    assign awprot      = 3'b000;
    assign arprot      = 3'b000;
    assign awvalid     = awvalid_q;
    assign wdata       = wdata_q;
    assign wstrb       = wstrb_q;
    assign wvalid      = wvalid_q;
    assign bready      = bready_q;
    assign arvalid     = arvalid_q;
    assign rready      = rready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign cmd_dropped = cmd_dropped_q;
    assign rdata_out   = rdata_out_q;
    assign resp_out    = resp_q;

endmodule

// File: tb/tb_axi_lite_master_ctrl.sv
// Scoreboard bench for axi_lite_master_ctrl with a delay-configurable slave.
module tb_axi_lite_master_ctrl;
    import axi_lite_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam time CLOCK_WIDTH = 5;

    logic          clk;
    logic          rst;
    logic          start_write, start_read;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          busy, done, cmd_dropped;
    logic [DW-1:0] rdata_out;
    logic [1:0]    resp_out;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    axi_lite_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .start_write(start_write), .start_read(start_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .busy(busy), .done(done), .rdata_out(rdata_out), .resp_out(resp_out),
        .cmd_dropped(cmd_dropped),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #CLOCK_WIDTH clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    int unsigned cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    int unsigned aw_d = 0, w_d = 0, ar_d = 0, r_d = 0;
    int unsigned aw_cnt, w_cnt, ar_cnt, r_cnt;
    logic        aw_seen, w_seen, ar_seen, r_pend;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;

    assign awready = awvalid && (aw_cnt >= aw_d);
    assign wready  = wvalid  && (w_cnt  >= w_d);
    assign arready = arvalid && (ar_cnt >= ar_d);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; ar_seen <= 1'b0; r_pend <= 1'b0;
            bvalid <= 1'b0; bresp <= 2'b00;
            rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
        end else begin
            if (awvalid && awready) begin aw_cnt <= 0; aw_seen <= 1'b1; end
            else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready) begin w_cnt <= 0; w_seen <= 1'b1; end
            else if (wvalid) w_cnt <= w_cnt + 1;
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0;
            end else if ((aw_seen || (awvalid && awready)) && (w_seen || (wvalid && wready))) begin
                bvalid <= 1'b1; bresp <= cfg_bresp;
            end
            if (arvalid && arready) begin
                ar_cnt <= 0; ar_seen <= 1'b1;
                if (r_d == 0) begin
                    rvalid <= 1'b1; rdata <= cfg_rdata; rresp <= cfg_rresp;
                end else begin
                    r_pend <= 1'b1; r_cnt <= 1;
                end
            end else if (arvalid) ar_cnt <= ar_cnt + 1;
            if (r_pend) begin
                if (r_cnt == r_d) begin
                    rvalid <= 1'b1; rdata <= cfg_rdata; rresp <= cfg_rresp; r_pend <= 1'b0;
                end else r_cnt <= r_cnt + 1;
            end
            if (rvalid && rready) begin rvalid <= 1'b0; ar_seen <= 1'b0; end
        end
    end

    // ---------------- protocol checker ----------------
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;

    always @(negedge clk) begin
        if (rst) begin
            p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
        end else begin
            if (p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_wv && !p_wr)   chk("w_hold", {wvalid, wstrb, wdata}, {1'b1, p_wstrb, p_wdata});
            if (p_arv && !p_arr) chk("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
            if (bready) chk("bready_early", aw_seen && w_seen, 1);
            if (rready) chk("rready_early", ar_seen, 1);
            p_awv <= awvalid; p_awr <= awready; p_awaddr <= awaddr;
            p_wv <= wvalid; p_wr <= wready; p_wdata <= wdata; p_wstrb <= wstrb;
            p_arv <= arvalid; p_arr <= arready; p_araddr <= araddr;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_done: got done=1, required done=0 (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("rdata_out", rdata_out, mon_e.rdata);
                chk("resp_out", resp_out, mon_e.resp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic wr, input logic rd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         input logic exp_drop, input bit push, input int unsigned lat,
                         input logic [31:0] erd, input logic [1:0] eresp);
        exp_t e;
        @(negedge clk);
        start_write = wr; start_read = rd;
        cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        @(posedge clk);
        #1;
        start_write = 1'b0; start_read = 1'b0;
        if (push) begin
            e.rdata = erd; e.resp = eresp; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("busy_after_accept", busy, 1);
        chk("cmd_dropped_on_accept", cmd_dropped, exp_drop);
    endtask

    task automatic wait_idle(input bit forbid_ar);
        bit          seen_ar = 1'b0;
        int unsigned n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            seen_ar |= arvalid;
            n++;
        end
        if (busy) begin
            vectors++;
            errors++;
            $display("FAIL idle_timeout: got busy=1, required busy=0 within 300 cycles");
        end
        chk("sb_drained", 64'(sb.size()), 0);
        if (forbid_ar) chk("no_arvalid", seen_ar, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {awvalid, wvalid, bready, arvalid, rready, busy, done, cmd_dropped}, 0);
        chk({tag, "_rdata_out"}, rdata_out, 0);
        chk({tag, "_resp_out"}, resp_out, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required $finish before 100000 time units");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_write = 1'b0; start_read = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        chk("prot", {awprot, arprot}, 0);
        rst = 1'b0;

        // zero-wait write
        aw_d = 0; w_d = 0; cfg_bresp = OKAY;
        issue(1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1, 3, 32'h0, OKAY);
        chk("wr0_bus", {awvalid, wvalid, arvalid, awaddr, wstrb}, {1'b1, 1'b1, 1'b0, 32'h10, 4'hF});
        chk("wr0_wdata", wdata, 32'hDEAD_BEEF);
        wait_idle(1);

        // split write: AW stalls 3 cycles, W immediate, SLVERR
        aw_d = 3; w_d = 0; cfg_bresp = SLVERR;
        issue(1, 0, 32'h0000_0024, 32'hCAFE_F00D, 4'h3, 0, 1, 6, 32'h0, SLVERR);
        @(negedge clk);
        chk("split_w_first", {awvalid, wvalid, bready}, 3'b100);
        chk("split_awaddr", awaddr, 32'h24);
        wait_idle(1);

        // delayed read, DECERR
        ar_d = 2; r_d = 4; cfg_rdata = 32'h1234_5678; cfg_rresp = DECERR;
        issue(0, 1, 32'h0000_0100, 32'h0, 4'h0, 0, 1, 8, 32'h1234_5678, DECERR);
        chk("rd_bus", {arvalid, awvalid, wvalid, araddr}, {1'b1, 1'b0, 1'b0, 32'h100});
        wait_idle(0);

        // simultaneous start: write wins, read dropped
        aw_d = 0; w_d = 0; cfg_bresp = OKAY;
        issue(1, 1, 32'h0000_0040, 32'h0BAD_CAFE, 4'hC, 1, 1, 3, 32'h1234_5678, OKAY);
        chk("both_bus", {awvalid, arvalid}, 2'b10);
        wait_idle(1);

        // read requested while a write is in flight
        aw_d = 4; w_d = 2; cfg_bresp = EXOKAY;
        issue(1, 0, 32'h0000_0080, 32'h5A5A_A5A5, 4'hF, 0, 1, 7, 32'h1234_5678, EXOKAY);
        @(negedge clk);
        start_read = 1'b1; cmd_addr = 32'h0000_0F00;
        @(posedge clk);
        #1;
        start_read = 1'b0;
        @(negedge clk);
        chk("busy_read_dropped", {cmd_dropped, arvalid}, 2'b10);
        @(negedge clk);
        chk("drop_one_cycle", cmd_dropped, 0);
        wait_idle(1);

        // reset while AW is stalled
        aw_d = 50; w_d = 0;
        issue(1, 0, 32'h0000_00C0, 32'h1111_2222, 4'hF, 0, 0, 0, 32'h0, OKAY);
        @(negedge clk);
        chk("stall_awvalid", {awvalid, awready}, 2'b10);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("async_reset");
        aw_d = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_done_after_reset", {busy, done}, 0);

        // read after the abandoned write
        ar_d = 0; r_d = 0; cfg_rdata = 32'hA5A5_0F0F; cfg_rresp = OKAY;
        issue(0, 1, 32'h0000_0200, 32'h0, 4'h0, 0, 1, 2, 32'hA5A5_0F0F, OKAY);
        wait_idle(0);

        // back-to-back zero-wait read, SLVERR
        cfg_rdata = 32'h5555_AAAA; cfg_rresp = SLVERR;
        issue(0, 1, 32'h0000_0204, 32'h0, 4'h0, 0, 1, 2, 32'h5555_AAAA, SLVERR);
        wait_idle(0);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
